vga_fb_arbiter: RTL

- Shares one single-port framebuffer RAM (1-cycle read latency) between the VGA scanout path and a host read/write port.
- Scanout has absolute priority while the sync generator's fetch window is active. The host is served only in blanking cycles.
- Sits between the VGA sync generator (pixel coordinates) and the framebuffer RAM. Feeds pixel data to the colour output stage.

---
 rtl/vga_fb_arbiter_if.sv | 34 +++
 rtl/vga_fb_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter_if.sv
// Host access bus for the framebuffer arbiter: request/grant handshake plus
// the fixed-latency read response channel.
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    modport master (
        output host_req,
        output host_we,
        output host_addr,
        output host_wdata,
        input  host_gnt,
        input  host_rvalid,
        input  host_rdata
    );

    modport slave (
        input  host_req,
        input  host_we,
        input  host_addr,
        input  host_wdata,
        output host_gnt,
        output host_rvalid,
        output host_rdata
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scanout owns the RAM while fetching, the host
// gets blanking cycles. Optional stall statistics via VGA_FB_ARB_STATS_EN.
module vga_fb_arbiter #(
    parameter int H_DISPLAY = 640,
    parameter int V_DISPLAY = 480,
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_active,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data,
    vga_fb_arbiter_if.slave   host,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef VGA_FB_ARB_STATS_EN
    ,
    output logic [15:0]       stat_stall_max
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] FB_WORDS = (ADDR_W + 1)'(H_DISPLAY * V_DISPLAY);

    state_t            state;
    state_t            next_state;
    logic              scan_own;
    logic              host_oor;
    logic [ADDR_W-1:0] scan_addr;

    logic              s1_scan;
    logic              s1_hrd;
    logic              s1_oor;
    logic              s2_scan;
    logic              s2_hrd;
    logic              s2_oor;

    assign scan_addr = ADDR_W'(pixel_y) * ADDR_W'(H_DISPLAY) + ADDR_W'(pixel_x);
    assign host_oor  = ({1'b0, host.host_addr} >= FB_WORDS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Scanout is only trusted once a frame start has been seen; grant is gated by rst.
    always_comb begin
        next_state    = state;
        scan_own      = 1'b0;
        host.host_gnt = 1'b0;
        case (state)
            IDLE: begin
                if (scan_active && (pixel_x == 10'd0) && (pixel_y == 10'd0)) begin
                    next_state = SCAN;
                end
            end
            SCAN: begin
                if (!scan_active) begin
                    next_state = BLANK;
                end
            end
            BLANK: begin
                if (scan_active) begin
                    next_state = SCAN;
                end
            end
            default: next_state = IDLE;
        endcase
        scan_own      = (state != IDLE) && scan_active;
        host.host_gnt = host.host_req && !scan_own && !rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            s1_scan   <= 1'b0;
            s1_hrd    <= 1'b0;
            s1_oor    <= 1'b0;
        end else begin
            s1_scan <= scan_own;
            s1_hrd  <= host.host_gnt && !host.host_we;
            s1_oor  <= host.host_gnt && host_oor;
            if (scan_own) begin
                mem_en   <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= scan_addr;
            end else if (host.host_gnt && !host_oor) begin
                mem_en    <= 1'b1;
                mem_we    <= host.host_we;
                mem_addr  <= host.host_addr;
                mem_wdata <= host.host_wdata;
            end else begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
            end
        end
    end

    // Tags travel alongside the RAM access so the response lands exactly three cycles after the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_scan          <= 1'b0;
            s2_hrd           <= 1'b0;
            s2_oor           <= 1'b0;
            pix_valid        <= 1'b0;
            pix_data         <= '0;
            host.host_rvalid <= 1'b0;
            host.host_rdata  <= '0;
        end else begin
            s2_scan          <= s1_scan;
            s2_hrd           <= s1_hrd;
            s2_oor           <= s1_oor;
            pix_valid        <= s2_scan;
            host.host_rvalid <= s2_hrd;
            if (s2_scan) begin
                pix_data <= mem_rdata;
            end
            if (s2_hrd) begin
                host.host_rdata <= s2_oor ? '0 : mem_rdata;
            end
        end
    end

`ifdef VGA_FB_ARB_STATS_EN
    logic [15:0] stall_run;
    logic [15:0] stall_next;

    assign stall_next = (stall_run == 16'hFFFF) ? stall_run : stall_run + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_run      <= '0;
            stat_stall_max <= '0;
        end else if (host.host_req && !host.host_gnt) begin
            stall_run <= stall_next;
            if (stall_next > stat_stall_max) begin
                stat_stall_max <= stall_next;
            end
        end else begin
            stall_run <= '0;
        end
    end
`endif

endmodule
